// File: rtl/dds_pkg.sv
// Shared encodings for the DDS sweep controller.
//   mode_e  : sweep mode as presented on cfg_mode (11 behaves as fixed)
//   state_e : controller FSM states
//   ACC_LAT_DEF : default accumulator pipeline latency in cycles
package dds_pkg;

  localparam int unsigned ACC_LAT_DEF = 4;

  typedef enum logic [1:0] {
    MODE_FIXED  = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_UP,
    ST_DOWN,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Configuration handshake and accumulator-drive bundle of the sweep controller.
//   cfg_valid/cfg_ready       : configuration offer / accept (accept = both high)
//   cfg_start/stop/step       : sweep words (unsigned, WIDTH bits)
//   cfg_dwell                 : extra cycles held per step
//   cfg_mode, cfg_phase_clr, cfg_neg : mode, phase clear on start, subtract mode
//   ftw, acc_clr, acc_add_sub : accumulator tuning word, clear, add/sub select
//   phase_valid               : accumulator output valid
// master = configuration source / accumulator side, slave = controller.
interface dds_sweep_ctrl_if
  import dds_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DWELL_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [WIDTH-1:0]   cfg_start;
  logic [WIDTH-1:0]   cfg_stop;
  logic [WIDTH-1:0]   cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  mode_e              cfg_mode;
  logic               cfg_phase_clr;
  logic               cfg_neg;
  logic [WIDTH-1:0]   ftw;
  logic               acc_clr;
  logic               acc_add_sub;
  logic               phase_valid;

  modport master (
    output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_mode,
           cfg_phase_clr, cfg_neg,
    input  cfg_ready, ftw, acc_clr, acc_add_sub, phase_valid
  );

  modport slave (
    input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_mode,
           cfg_phase_clr, cfg_neg,
    output cfg_ready, ftw, acc_clr, acc_add_sub, phase_valid
  );
endinterface

// File: rtl/dds_step_clamp.sv
// Clamped single step of the tuning word.
//   cur   : current word          step : step size
//   limit : stop (dir=0) or start (dir=1) word
//   dir   : 0 = add toward limit, 1 = subtract toward limit
//   next  : stepped word, never past limit and never wrapped
//   hit   : next sits at the limit (or cur was already at/past it)
module dds_step_clamp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  output logic [WIDTH-1:0] next,
  output logic             hit
);
  // One extra bit so carry-out / borrow clamp instead of wrapping.
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, cur} + {1'b0, step};
  assign w_diff = {1'b0, cur} - {1'b0, step};

  always_comb begin
    next = cur;
    hit  = 1'b0;
    if (!dir) begin
      // Already at/past the limit: hold the word (covers stop <= start).
      if (cur >= limit) begin
        hit = 1'b1;
      end else if (w_sum >= {1'b0, limit}) begin
        next = limit;
        hit  = 1'b1;
      end else begin
        next = w_sum[WIDTH-1:0];
      end
    end else begin
      if (cur <= limit) begin
        hit = 1'b1;
      end else if (w_diff[WIDTH] || (w_diff[WIDTH-1:0] <= limit)) begin
        next = limit;
        hit  = 1'b1;
      end else begin
        next = w_diff[WIDTH-1:0];
      end
    end
  end
endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep controller: captures a sweep configuration and drives
// the phase accumulator's tuning word through fixed, single or triangle sweeps.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   run          : level enable; low returns to IDLE (configuration kept)
//   busy         : FSM not in IDLE
//   sweep_done   : one-cycle pulse when a single sweep reaches stop
//   bus          : configuration handshake and accumulator drive (slave side)
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned ACC_LAT = ACC_LAT_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  output logic            busy,
  output logic            sweep_done,
  dds_sweep_ctrl_if.slave bus
);
  state_e             r_state, w_next;
  logic [WIDTH-1:0]   r_ftw, w_ftw_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_done, w_done_nxt;
  logic [ACC_LAT-1:0] r_pv_sr;
  logic               r_addsub;

  logic               r_have_cfg;
  logic [WIDTH-1:0]   r_start, r_stop, r_step;
  logic [DWELL_W-1:0] r_dwell;
  mode_e              r_mode;
  logic               r_phase_clr, r_neg;

  logic               w_accept, w_expire, w_dir, w_hit;
  logic [WIDTH-1:0]   w_limit, w_step_next;

  assign w_accept = bus.cfg_valid && (r_state == ST_IDLE);
  assign w_expire = (r_cnt == r_dwell);
  assign w_dir    = (r_state == ST_DOWN);
  assign w_limit  = w_dir ? r_start : r_stop;

  dds_step_clamp #(.WIDTH(WIDTH)) u_clamp (
    .cur  (r_ftw),
    .step (r_step),
    .limit(w_limit),
    .dir  (w_dir),
    .next (w_step_next),
    .hit  (w_hit)
  );

  always_comb begin
    w_next     = r_state;
    w_ftw_nxt  = r_ftw;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A configuration accepted on this edge can launch LOAD immediately.
        if (run && (r_have_cfg || w_accept)) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_ftw_nxt = r_start;
        w_cnt_nxt = '0;
        w_next    = (r_mode == MODE_SINGLE || r_mode == MODE_TRI) ? ST_UP : ST_HOLD;
      end
      ST_UP, ST_DOWN: begin
        if (w_expire) begin
          w_ftw_nxt = w_step_next;
          w_cnt_nxt = '0;
          if (w_hit) begin
            if (r_state == ST_DOWN) begin
              w_next = ST_UP;
            end else if (r_mode == MODE_TRI) begin
              w_next = ST_DOWN;
            end else begin
              w_next     = ST_HOLD;
              w_done_nxt = 1'b1;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + DWELL_W'(1);
        end
      end
      default: ;
    endcase
    if (!run && r_state != ST_IDLE) begin
      w_next     = ST_IDLE;
      w_ftw_nxt  = '0;
      w_done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ftw       <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_pv_sr     <= '0;
      r_addsub    <= 1'b0;
      r_have_cfg  <= 1'b0;
      r_start     <= '0;
      r_stop      <= '0;
      r_step      <= '0;
      r_dwell     <= '0;
      r_mode      <= MODE_FIXED;
      r_phase_clr <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ftw   <= w_ftw_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      // Active indication shifted ACC_LAT deep; flushed on the way to IDLE.
      if (w_next == ST_IDLE) r_pv_sr <= '0;
      else r_pv_sr <= (r_pv_sr << 1) | ACC_LAT'(r_state != ST_IDLE);
      if (r_state == ST_LOAD) r_addsub <= r_neg;
      if (w_accept) begin
        r_have_cfg  <= 1'b1;
        r_start     <= bus.cfg_start;
        r_stop      <= bus.cfg_stop;
        r_step      <= bus.cfg_step;
        r_dwell     <= bus.cfg_dwell;
        r_mode      <= bus.cfg_mode;
        r_phase_clr <= bus.cfg_phase_clr;
        r_neg       <= bus.cfg_neg;
      end
    end
  end

  assign bus.cfg_ready   = (r_state == ST_IDLE);
  assign bus.ftw         = r_ftw;
  assign bus.acc_clr     = (r_state == ST_LOAD) && r_phase_clr;
  assign bus.acc_add_sub = (r_state == ST_LOAD) ? r_neg : r_addsub;
  assign bus.phase_valid = r_pv_sr[ACC_LAT-1];
  assign busy            = (r_state != ST_IDLE);
  assign sweep_done      = r_done;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed testbench for dds_sweep_ctrl (32-bit instance plus an 8-bit
// instance for the carry-clamp case).
module tb_dds_sweep_ctrl;
  import dds_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic run, run8;
  logic busy, done, busy8, done8;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.WIDTH(32), .DWELL_W(16)) bus ();
  dds_sweep_ctrl_if #(.WIDTH(8),  .DWELL_W(16)) bus8 ();

  dds_sweep_ctrl #(.WIDTH(32), .DWELL_W(16), .ACC_LAT(4)) dut (
    .clock(clk), .reset(rst), .run(run), .busy(busy), .sweep_done(done),
    .bus(bus.slave)
  );

  dds_sweep_ctrl #(.WIDTH(8), .DWELL_W(16), .ACC_LAT(4)) dut8 (
    .clock(clk), .reset(rst), .run(run8), .busy(busy8), .sweep_done(done8),
    .bus(bus8.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a configuration with run high; returns in the LOAD cycle.
  task automatic offer(input logic [31:0] start, input logic [31:0] stop,
                       input logic [31:0] step, input logic [15:0] dwell,
                       input mode_e mode, input logic clr, input logic neg);
    bus.cfg_start     = start;
    bus.cfg_stop      = stop;
    bus.cfg_step      = step;
    bus.cfg_dwell     = dwell;
    bus.cfg_mode      = mode;
    bus.cfg_phase_clr = clr;
    bus.cfg_neg       = neg;
    bus.cfg_valid     = 1'b1;
    run               = 1'b1;
    tick();
    bus.cfg_valid     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.ftw !== 32'h0) begin errors++; $display("FAIL reset_ftw got %h exp %h", bus.ftw, 32'h0); end
    checks++; if (bus.acc_clr !== 1'b0) begin errors++; $display("FAIL reset_acc_clr got %b exp 0", bus.acc_clr); end
    checks++; if (bus.acc_add_sub !== 1'b0) begin errors++; $display("FAIL reset_add_sub got %b exp 0", bus.acc_add_sub); end
    checks++; if (bus.phase_valid !== 1'b0) begin errors++; $display("FAIL reset_phase_valid got %b exp 0", bus.phase_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.cfg_ready); end
    run = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_cfg_busy got %b exp 0", busy); end
    run = 1'b0;
  endtask

  task automatic test_fixed();
    offer(32'h1000, 32'h0, 32'h0, 16'd0, MODE_FIXED, 1'b1, 1'b0);
    checks++; if (bus.acc_clr !== 1'b1) begin errors++; $display("FAIL fixed_load_clr got %b exp 1", bus.acc_clr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fixed_load_busy got %b exp 1", busy); end
    checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL fixed_load_ready got %b exp 0", bus.cfg_ready); end
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++; if (bus.acc_clr !== 1'b0) begin errors++; $display("FAIL fixed_clr k=%0d got %b exp 0", k, bus.acc_clr); end
      checks++; if (bus.ftw !== 32'h1000) begin errors++; $display("FAIL fixed_ftw k=%0d got %h exp %h", k, bus.ftw, 32'h1000); end
      checks++; if (bus.phase_valid !== (k >= 4)) begin errors++; $display("FAIL fixed_pv k=%0d got %b exp %b", k, bus.phase_valid, k >= 4); end
    end
    run = 1'b0;
    tick();
    checks++; if (bus.ftw !== 32'h0) begin errors++; $display("FAIL fixed_idle_ftw got %h exp 0", bus.ftw); end
    checks++; if (bus.phase_valid !== 1'b0) begin errors++; $display("FAIL fixed_idle_pv got %b exp 0", bus.phase_valid); end
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL fixed_idle_ready got %b exp 1", bus.cfg_ready); end
  endtask

  task automatic test_single();
    logic [31:0] exp_ftw;
    offer(32'd10, 32'd40, 32'd10, 16'd2, MODE_SINGLE, 1'b0, 1'b1);
    checks++; if (bus.acc_clr !== 1'b0) begin errors++; $display("FAIL single_load_clr got %b exp 0", bus.acc_clr); end
    checks++; if (bus.acc_add_sub !== 1'b1) begin errors++; $display("FAIL single_load_addsub got %b exp 1", bus.acc_add_sub); end
    for (int i = 0; i < 14; i++) begin
      tick();
      exp_ftw = (i < 9) ? 32'(10 * (i / 3 + 1)) : 32'd40;
      checks++; if (bus.ftw !== exp_ftw) begin errors++; $display("FAIL single_ftw i=%0d got %0d exp %0d", i, bus.ftw, exp_ftw); end
      checks++; if (done !== (i == 9)) begin errors++; $display("FAIL single_done i=%0d got %b exp %b", i, done, i == 9); end
      checks++; if (bus.acc_add_sub !== 1'b1) begin errors++; $display("FAIL single_addsub i=%0d got %b exp 1", i, bus.acc_add_sub); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_hold_busy got %b exp 1", busy); end
    run = 1'b0;
    tick();
    checks++; if (bus.acc_add_sub !== 1'b1) begin errors++; $display("FAIL single_idle_addsub got %b exp 1", bus.acc_add_sub); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_triangle();
    logic [31:0] exp_seq [11] = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd15, 32'd5,
                                  32'd0, 32'd10, 32'd20, 32'd25, 32'd15};
    offer(32'd0, 32'd25, 32'd10, 16'd0, MODE_TRI, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++; if (bus.ftw !== exp_seq[i]) begin errors++; $display("FAIL tri_ftw i=%0d got %0d exp %0d", i, bus.ftw, exp_seq[i]); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL tri_done i=%0d got %b exp 0", i, done); end
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_run_drop();
    run = 1'b1;
    tick();
    repeat (8) tick();
    checks++; if (bus.ftw !== 32'd10) begin errors++; $display("FAIL drop_pre_ftw got %0d exp 10", bus.ftw); end
    checks++; if (bus.phase_valid !== 1'b1) begin errors++; $display("FAIL drop_pre_pv got %b exp 1", bus.phase_valid); end
    bus.cfg_start = 32'h55;
    bus.cfg_valid = 1'b1;
    tick();
    checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL drop_busy_ready got %b exp 0", bus.cfg_ready); end
    checks++; if (bus.ftw !== 32'd20) begin errors++; $display("FAIL drop_up_ftw got %0d exp 20", bus.ftw); end
    bus.cfg_valid = 1'b0;
    run = 1'b0;
    tick();
    checks++; if (bus.ftw !== 32'h0) begin errors++; $display("FAIL drop_ftw got %h exp 0", bus.ftw); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b exp 0", busy); end
    checks++; if (bus.phase_valid !== 1'b0) begin errors++; $display("FAIL drop_pv got %b exp 0", bus.phase_valid); end
    checks++; if (bus.acc_clr !== 1'b0) begin errors++; $display("FAIL drop_clr got %b exp 0", bus.acc_clr); end
    run = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rerun_busy got %b exp 1", busy); end
    tick();
    checks++; if (bus.ftw !== 32'd0) begin errors++; $display("FAIL rerun_start got %h exp 0", bus.ftw); end
    tick();
    checks++; if (bus.ftw !== 32'd10) begin errors++; $display("FAIL rerun_step got %0d exp 10", bus.ftw); end
  endtask

  task automatic test_reset_in_down();
    repeat (3) tick();
    checks++; if (bus.ftw !== 32'd15) begin errors++; $display("FAIL down_ftw got %0d exp 15", bus.ftw); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.ftw !== 32'h0) begin errors++; $display("FAIL arst_ftw got %h exp 0", bus.ftw); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", busy); end
    checks++; if (bus.phase_valid !== 1'b0) begin errors++; $display("FAIL arst_pv got %b exp 0", bus.phase_valid); end
    checks++; if (bus.acc_add_sub !== 1'b0) begin errors++; $display("FAIL arst_addsub got %b exp 0", bus.acc_add_sub); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got %b exp 0", done); end
    #3 rst = 1'b0;
    repeat (2) tick();
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", bus.cfg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_cfg_cleared got busy %b exp 0", busy); end
    run = 1'b0;
  endtask

  task automatic test_stop_le_start();
    offer(32'd50, 32'd30, 32'd5, 16'd1, MODE_SINGLE, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (bus.ftw !== 32'd50) begin errors++; $display("FAIL sle_single_ftw i=%0d got %0d exp 50", i, bus.ftw); end
      checks++; if (done !== (i == 2)) begin errors++; $display("FAIL sle_single_done i=%0d got %b exp %b", i, done, i == 2); end
    end
    run = 1'b0;
    tick();
    offer(32'd50, 32'd30, 32'd5, 16'd1, MODE_TRI, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bus.ftw !== 32'd50) begin errors++; $display("FAIL sle_tri_ftw i=%0d got %0d exp 50", i, bus.ftw); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL sle_tri_done i=%0d got %b exp 0", i, done); end
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_step_zero();
    offer(32'd7, 32'd100, 32'd0, 16'd0, MODE_SINGLE, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.ftw !== 32'd7) begin errors++; $display("FAIL step0_ftw i=%0d got %0d exp 7", i, bus.ftw); end
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL step0_state i=%0d got busy %b done %b exp 1 0", i, busy, done); end
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_mode_rsvd();
    offer(32'h33, 32'h99, 32'h1, 16'd0, MODE_RSVD, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.ftw !== 32'h33) begin errors++; $display("FAIL mode11_ftw i=%0d got %h exp 33", i, bus.ftw); end
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_clamp8();
    logic [7:0] exp8;
    bus8.cfg_start = 8'hF0;
    bus8.cfg_stop  = 8'hFF;
    bus8.cfg_step  = 8'h20;
    bus8.cfg_dwell = 16'd0;
    bus8.cfg_mode  = MODE_SINGLE;
    bus8.cfg_valid = 1'b1;
    run8 = 1'b1;
    tick();
    bus8.cfg_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp8 = (i == 0) ? 8'hF0 : 8'hFF;
      checks++; if (bus8.ftw !== exp8) begin errors++; $display("FAIL clamp8_ftw i=%0d got %h exp %h", i, bus8.ftw, exp8); end
      checks++; if (done8 !== (i == 1)) begin errors++; $display("FAIL clamp8_done i=%0d got %b exp %b", i, done8, i == 1); end
    end
    run8 = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    run8 = 1'b0;
    bus.cfg_valid = 1'b0;  bus.cfg_start = '0; bus.cfg_stop = '0; bus.cfg_step = '0;
    bus.cfg_dwell = '0;    bus.cfg_mode = MODE_FIXED; bus.cfg_phase_clr = 1'b0; bus.cfg_neg = 1'b0;
    bus8.cfg_valid = 1'b0; bus8.cfg_start = '0; bus8.cfg_stop = '0; bus8.cfg_step = '0;
    bus8.cfg_dwell = '0;   bus8.cfg_mode = MODE_FIXED; bus8.cfg_phase_clr = 1'b0; bus8.cfg_neg = 1'b0;
    test_reset();
    test_fixed();
    test_single();
    test_triangle();
    test_run_drop();
    test_reset_in_down();
    test_stop_le_start();
    test_step_zero();
    test_mode_rsvd();
    test_clamp8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, tuning-word width; WIDTH SHALL be a multiple of 4.
REQ-002 SHALL have parameter DWELL_W, default 16, dwell counter width.
REQ-003 SHALL have parameter ACC_LAT, default 4, accumulator pipeline latency in cycles.
REQ-004 clock  in  1  single clock, all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cfg_valid  in  1  configuration offer.
REQ-007 cfg_ready  out  1  configuration accepted when cfg_valid and cfg_ready are high on the same edge.
REQ-008 cfg_start, cfg_stop, cfg_step  in  WIDTH each  sweep start word, stop word, step size (unsigned).
REQ-009 cfg_dwell  in  DWELL_W  extra cycles held per step (0 = step every cycle).
REQ-010 cfg_mode  in  2  00 fixed, 01 single sweep, 10 triangle, 11 treated as 00.
REQ-011 cfg_phase_clr, cfg_neg  in  1 each  clear phase on start; run accumulator in subtract mode.
REQ-012 run  in  1  level enable; low forces return to IDLE.
REQ-013 ftw  out  WIDTH  tuning word to accumulator D input.
REQ-014 acc_clr, acc_add_sub  out  1 each  accumulator clear and add/sub select.
REQ-015 phase_valid, busy, sweep_done  out  1 each  accumulator output valid; not IDLE; one-cycle end-of-sweep pulse.

Function
REQ-016 SHALL implement states IDLE, LOAD, UP, DOWN, HOLD.
REQ-017 cfg_ready SHALL be high only in IDLE; an accepted configuration SHALL be registered whole and move the FSM to LOAD on the next edge if run is high, else remain captured in IDLE.
REQ-018 In IDLE with run high and a captured configuration, the FSM SHALL enter LOAD.
REQ-019 LOAD SHALL last exactly one cycle: ftw <= cfg_start, acc_clr = cfg_phase_clr, acc_add_sub = cfg_neg; the next state is HOLD for mode 00 and UP otherwise.
REQ-020 In UP, after cfg_dwell+1 cycles at the current word, ftw SHALL become min(ftw+step, stop), computed with a WIDTH+1-bit sum so that carry-out clamps to stop.
REQ-021 When ftw equals stop in UP, mode 01 SHALL go to HOLD and pulse sweep_done for one cycle; mode 10 SHALL go to DOWN with the dwell counter restarted.
REQ-022 In DOWN, ftw SHALL become max(ftw-step, start) with borrow clamping to start; on reaching start, the FSM SHALL go to UP without a sweep_done pulse.
REQ-023 If stop <= start, UP SHALL treat the start word as already at stop: single sweep reaches HOLD after one dwell period, and triangle holds at start.
REQ-024 step = 0 SHALL hold ftw constant without deadlock; the FSM SHALL remain in UP until run drops.
REQ-025 HOLD SHALL keep ftw constant until run drops.
REQ-026 run low in any non-IDLE state SHALL force IDLE on the next edge: ftw <= 0, so the accumulator holds phase; acc_clr = 0; the captured configuration is retained.
REQ-027 phase_valid SHALL assert ACC_LAT cycles after LOAD and deassert on the first cycle of IDLE; it SHALL be implemented with an ACC_LAT-deep shift of the LOAD/active indication.
REQ-028 acc_clr SHALL be high only in LOAD; acc_add_sub SHALL be constant outside LOAD, holding the cfg_neg value latched at LOAD.
REQ-029 A cfg_valid asserted outside IDLE SHALL be ignored: no capture, and cfg_ready stays low.

Reset
REQ-030 Reset SHALL force IDLE with ftw = 0, acc_clr = 0, acc_add_sub = 0, phase_valid = 0, sweep_done = 0, busy = 0, cfg_ready = 1 after reset release, and no configuration captured.
REQ-031 Reset asserted mid-sweep SHALL take effect asynchronously with no partial step completed.

Structure
REQ-032 Mode encodings, state encodings and ACC_LAT default SHALL live in a shared package dds_pkg.
REQ-033 Clamped add/subtract step logic SHALL be one sub-module, dds_step_clamp (inputs: cur, step, limit, dir; output: next, hit).

Verification
REQ-034 Mode 00, start = 0x1000, phase_clr = 1, run = 1 -> acc_clr high for one cycle, ftw = 0x1000 steady, phase_valid high 4 cycles after LOAD.
REQ-035 Mode 01, start = 10, stop = 40, step = 10, dwell = 2 -> ftw sequence 10, 20, 30, 40, each held 3 cycles; sweep_done pulses once; FSM ends in HOLD.
REQ-036 Mode 10, start = 0, stop = 25, step = 10, dwell = 0 -> ftw 0, 10, 20, 25, 15, 5, 0, 10 …; sweep_done never asserts.
REQ-037 WIDTH = 8, start = 0xF0, stop = 0xFF, step = 0x20 -> ftw clamps 0xF0 to 0xFF with no wrap.
REQ-038 run drops mid-UP -> next cycle ftw = 0, busy = 0, phase_valid = 0; run re-raised -> restarts from start without a new config.
REQ-039 Reset pulse in DOWN -> all outputs at reset values immediately; cfg_ready = 1 after release.
